// File: rtl/sfu_requant_if.sv
// sfu_requant_if: upstream product beat and downstream result stream for the requant stage
interface sfu_requant_if #(
  parameter int PROD_WIDTH  = 30,
  parameter int SHIFT_WIDTH = 5,
  parameter int OUT_WIDTH   = 8
);
  logic                          in_valid;
  logic                          in_ready;
  logic signed [PROD_WIDTH-1:0]  in_product;
  logic        [SHIFT_WIDTH-1:0] in_shift;
  logic signed [OUT_WIDTH-1:0]   in_zero_point;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [OUT_WIDTH-1:0]   out_data;
  logic                          out_sat;
  modport master (
    output in_valid, in_product, in_shift, in_zero_point, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );
  modport slave (
    input  in_valid, in_product, in_shift, in_zero_point, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/sfu_requant_stage.sv
// sfu_requant_stage: round, shift, offset and saturate a signed product in a 2-stage pipeline
module sfu_requant_stage #(
  parameter int PROD_WIDTH  = 30,
  parameter int SHIFT_WIDTH = 5,
  parameter int OUT_WIDTH   = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  sfu_requant_if.slave         bus,
  output logic [CNT_WIDTH-1:0] sat_count,
  input  logic                 sat_count_clr
);
  // r must hold the product plus a rounding term as large as 2^(max_shift-1)
  localparam int SMAX = (1 << SHIFT_WIDTH) - 1;
  localparam int RW   = (PROD_WIDTH > SMAX ? PROD_WIDTH : SMAX) + 1;
  localparam int TW   = RW + 1;
  localparam logic signed [OUT_WIDTH-1:0] O_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] O_MIN = ~O_MAX;
  localparam logic signed [TW-1:0]        T_MAX = TW'(O_MAX);
  localparam logic signed [TW-1:0]        T_MIN = TW'(O_MIN);
  logic                          s1_valid, s1_load, s2_load, hi, lo;
  logic signed [RW-1:0]          s1_r, rnd, r_in;
  logic        [SHIFT_WIDTH-1:0] s1_shift;
  logic signed [OUT_WIDTH-1:0]   s1_zp;
  logic signed [TW-1:0]          t;
  always_comb begin
    s2_load      = !bus.out_valid || bus.out_ready;
    s1_load      = !s1_valid || s2_load;
    bus.in_ready = s1_load;
    rnd          = (bus.in_shift == '0) ? '0 : RW'(1) << (bus.in_shift - 1'b1);
    r_in         = RW'(bus.in_product) + rnd;
    t            = TW'(s1_r >>> s1_shift) + TW'(s1_zp);
    hi           = t > T_MAX;
    lo           = t < T_MIN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_r          <= '0;
      s1_shift      <= '0;
      s1_zp         <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sat   <= 1'b0;
      sat_count     <= '0;
    end else begin
      if (s1_load) s1_valid <= bus.in_valid;
      if (s1_load && bus.in_valid) begin
        s1_r     <= r_in;
        s1_shift <= bus.in_shift;
        s1_zp    <= bus.in_zero_point;
      end
      if (s2_load) bus.out_valid <= s1_valid;
      if (s2_load && s1_valid) begin
        bus.out_data <= hi ? O_MAX : lo ? O_MIN : t[OUT_WIDTH-1:0];
        bus.out_sat  <= hi || lo;
      end
      if (sat_count_clr) sat_count <= '0;
      else if (bus.out_valid && bus.out_ready && bus.out_sat && !(&sat_count)) sat_count <= sat_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_sfu_requant_stage.sv
// tb_sfu_requant_stage: directed vector table plus handshake, counter and reset sequences
module tb_sfu_requant_stage;
  localparam int PW = 30, SW = 5, OW = 8, CW = 16;
  typedef struct {
    logic signed [PW-1:0] p;
    logic        [SW-1:0] sh;
    logic signed [OW-1:0] zp;
    logic signed [OW-1:0] d;
    logic                 s;
  } vec_t;
  logic          clk = 1'b0, rst = 1'b1, sat_count_clr = 1'b0;
  logic [CW-1:0] sat_count;
  vec_t          tbl[14];
  int            n_vec = 0, n_bad = 0, exp_cnt = 0;
  sfu_requant_if #(.PROD_WIDTH(PW), .SHIFT_WIDTH(SW), .OUT_WIDTH(OW)) bus();
  sfu_requant_stage #(.PROD_WIDTH(PW), .SHIFT_WIDTH(SW), .OUT_WIDTH(OW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .sat_count(sat_count), .sat_count_clr(sat_count_clr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask
  task automatic drive(input logic signed [PW-1:0] p, input logic [SW-1:0] sh, input logic signed [OW-1:0] zp);
    bus.in_product    = p;
    bus.in_shift      = sh;
    bus.in_zero_point = zp;
    bus.in_valid      = 1'b1;
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_product = '0;
    bus.in_shift = '0;
    bus.in_zero_point = '0;
    bus.out_ready = 1'b1;
    tbl[0]  = '{30'sd1000,        5'd4,  8'sd0,   8'sd63,   1'b0};
    tbl[1]  = '{-30'sd1000,       5'd4,  8'sd0,   -8'sd62,  1'b0};
    tbl[2]  = '{30'sd40,          5'd2,  -8'sd5,  8'sd5,    1'b0};
    tbl[3]  = '{-30'sd3,          5'd0,  8'sd0,   -8'sd3,   1'b0};
    tbl[4]  = '{30'sd100000,      5'd0,  8'sd0,   8'sd127,  1'b1};
    tbl[5]  = '{-30'sd100000,     5'd0,  8'sd0,   -8'sd128, 1'b1};
    tbl[6]  = '{30'sh1FFFFFFF,    5'd0,  8'sd127, 8'sd127,  1'b1};
    tbl[7]  = '{30'sh1FFFFFFF,    5'd31, 8'sd0,   8'sd0,    1'b0};
    tbl[8]  = '{-30'sd8,          5'd4,  8'sd0,   8'sd0,    1'b0};
    tbl[9]  = '{30'sd24,          5'd4,  8'sd3,   8'sd5,    1'b0};
    tbl[10] = '{30'sd127,         5'd0,  8'sd0,   8'sd127,  1'b0};
    tbl[11] = '{30'sd128,         5'd0,  8'sd0,   8'sd127,  1'b1};
    tbl[12] = '{-30'sd129,        5'd0,  8'sd1,   -8'sd128, 1'b0};
    tbl[13] = '{30'sd100,         5'd0,  8'sd28,  8'sd127,  1'b1};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst out_data", bus.out_data, 0);
    chk("rst out_sat", bus.out_sat, 0);
    chk("rst sat_count", sat_count, 0);
    chk("rst in_ready", bus.in_ready, 1);
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].p, tbl[i].sh, tbl[i].zp);
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk($sformatf("vec%0d early", i), bus.out_valid, 0);
      @(negedge clk);
      chk($sformatf("vec%0d valid", i), bus.out_valid, 1);
      chk($sformatf("vec%0d data", i), bus.out_data, tbl[i].d);
      chk($sformatf("vec%0d sat", i), bus.out_sat, tbl[i].s);
      exp_cnt += int'(tbl[i].s);
    end
    @(negedge clk);
    chk("table drained", bus.out_valid, 0);
    chk("table sat_count", sat_count, exp_cnt);
    bus.out_ready = 1'b0;
    drive(30'sd16, 5'd4, 8'sd0);
    @(negedge clk);
    chk("bp ready after A", bus.in_ready, 1);
    drive(30'sd32, 5'd4, 8'sd0);
    @(negedge clk);
    chk("bp full ready", bus.in_ready, 0);
    chk("bp A valid", bus.out_valid, 1);
    chk("bp A data", bus.out_data, 1);
    drive(30'sd48, 5'd4, 8'sd0);
    @(negedge clk);
    chk("bp held ready", bus.in_ready, 0);
    chk("bp A stable", bus.out_data, 1);
    bus.out_ready = 1'b1;
    #1;
    chk("bp ready comb", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("bp B data", bus.out_data, 2);
    @(negedge clk);
    chk("bp C valid", bus.out_valid, 1);
    chk("bp C data", bus.out_data, 3);
    @(negedge clk);
    chk("bp drained", bus.out_valid, 0);
    sat_count_clr = 1'b1;
    @(negedge clk);
    sat_count_clr = 1'b0;
    chk("cnt clear", sat_count, 0);
    drive(30'sd100000, 5'd0, 8'sd0);
    repeat (5) @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("cnt five", sat_count, 5);
    drive(30'sd100000, 5'd0, 8'sd0);
    repeat (65540) @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("cnt sticky max", sat_count, 65535);
    drive(-30'sd100000, 5'd0, 8'sd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("clr beat sat", bus.out_sat, 1);
    sat_count_clr = 1'b1;
    @(negedge clk);
    sat_count_clr = 1'b0;
    chk("clr priority", sat_count, 0);
    chk("clr beat gone", bus.out_valid, 0);
    drive(30'sd100000, 5'd0, 8'sd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("cnt after clr", sat_count, 1);
    bus.out_ready = 1'b0;
    drive(30'sd16, 5'd4, 8'sd0);
    @(negedge clk);
    drive(30'sd32, 5'd4, 8'sd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("mid full", bus.out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid out_valid", bus.out_valid, 0);
    chk("mid sat_count", sat_count, 0);
    chk("mid in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("mid dropped %0d", k), bus.out_valid, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
